// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner.
//   SEG_BLANK  : all segments (and DP) off, active-low
//   SEG_TABLE  : hex-to-segment glyphs {a,b,c,d,e,f,g,dp}, dp bit = 1 (off)
//   hex_to_seg : table lookup for one nibble
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry [n] is the glyph for nibble n (index 15 is listed first).
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'b01110001,  // F
    8'b01100001,  // E
    8'b10000101,  // d
    8'b01100011,  // C
    8'b11000001,  // b
    8'b00010001,  // A
    8'b00001001,  // 9
    8'b00000001,  // 8
    8'b00011111,  // 7
    8'b01000001,  // 6
    8'b01001001,  // 5
    8'b10011001,  // 4
    8'b00001101,  // 3
    8'b00100101,  // 2
    8'b10011111,  // 1
    8'b00000011   // 0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero blank mask for the 7-segment scanner.
//   i_value   : packed hex nibbles, leftmost digit in the top nibble
//   o_lz_mask : bit i set when scan slot i (0 = leftmost) and every digit to
//               its left are zero; the rightmost slot is never flagged
module seg7_lz_mask
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] i_value,
  output logic [NUM_DIGITS-1:0]   o_lz_mask
);

  logic w_zero_run;

  // Walk from the leftmost digit; the run of zeros breaks at the first non-zero.
  always_comb begin
    w_zero_run = 1'b1;
    o_lz_mask  = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      w_zero_run   = w_zero_run & (i_value[4*(int'(NUM_DIGITS)-1-i) +: 4] == 4'h0);
      o_lz_mask[i] = w_zero_run && (i != int'(NUM_DIGITS) - 1);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with prescaler, frame-consistent
// shadow latching, leading-zero blanking, per-digit DP/blink and PWM dimming.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_value         : hex nibbles, top nibble is the leftmost digit
//   i_dp_mask       : 1 = light DP (bit N-1 = leftmost digit)
//   i_blink_mask    : 1 = digit blinks
//   i_blank_lz      : 1 = suppress leading zeros
//   i_brightness    : 0 = 1/16 duty .. 15 = full duty (sampled live)
//   o_digit_sel     : active-low anode enables (bit N-1 = leftmost digit)
//   o_seg           : active-low segments {a,b,c,d,e,f,g,dp}
//   o_frame_start   : one-cycle pulse after the scan wraps to the leftmost digit
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DIV_LOG2     = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp_mask,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  input  logic                    i_blank_lz,
  input  logic [3:0]              i_brightness,
  output logic [NUM_DIGITS-1:0]   o_digit_sel,
  output logic [7:0]              o_seg,
  output logic                    o_frame_start
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(BLINK_FRAMES - 1);

  // State
  logic [DIV_LOG2-1:0]   r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_value;
  logic [NUM_DIGITS-1:0] r_sh_dp;
  logic [NUM_DIGITS-1:0] r_sh_blink;
  logic                  r_sh_blank_lz;
  logic [FRM_W-1:0]      r_frame_cnt;
  logic                  r_blink_phase;
  logic                  r_frame_start;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_digit_sel;

  // Next-state / decode
  logic                  w_tick;
  logic                  w_wrap;
  logic [IDX_W-1:0]      w_idx_next;
  logic [FRM_W-1:0]      w_frame_cnt_next;
  logic                  w_blink_phase_next;
  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic [3:0]            w_nibble;
  logic                  w_dp_on;
  logic                  w_blink_en;
  logic                  w_lz_here;
  logic [NUM_DIGITS-1:0] w_anode;
  logic [3:0]            w_phase;
  logic [7:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_sel_next;

  assign w_tick = &r_cnt;
  // Frame boundary: last cycle of the rightmost digit's slot.
  assign w_wrap = w_tick && (r_idx == LAST_IDX);

  always_comb begin
    w_idx_next = r_idx;
    if (w_tick) begin
      w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  always_comb begin
    w_frame_cnt_next   = r_frame_cnt;
    w_blink_phase_next = r_blink_phase;
    if (w_wrap) begin
      if (r_frame_cnt == LAST_FRM) begin
        w_frame_cnt_next   = '0;
        w_blink_phase_next = ~r_blink_phase;
      end else begin
        w_frame_cnt_next = r_frame_cnt + 1'b1;
      end
    end
  end

  // Blank mask is computed from the shadow so it stays frame-consistent.
  seg7_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .i_value  (r_sh_value),
    .o_lz_mask(w_lz_mask)
  );

  // Select the per-digit attributes for the current scan slot.
  always_comb begin
    w_nibble   = '0;
    w_dp_on    = 1'b0;
    w_blink_en = 1'b0;
    w_lz_here  = 1'b0;
    w_anode    = '1;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (r_idx == IDX_W'(d)) begin
        w_nibble   = r_sh_value[4*(int'(NUM_DIGITS)-1-d) +: 4];
        w_dp_on    = r_sh_dp[int'(NUM_DIGITS)-1-d];
        w_blink_en = r_sh_blink[int'(NUM_DIGITS)-1-d];
        w_lz_here  = w_lz_mask[d];
        w_anode[int'(NUM_DIGITS)-1-d] = 1'b0;
      end
    end
  end

  assign w_phase = r_cnt[DIV_LOG2-1 -: 4];

  always_comb begin
    w_seg_next = hex_to_seg(w_nibble);
    if (r_sh_blank_lz && w_lz_here) begin
      w_seg_next[7:1] = '1;
    end
    w_seg_next[0] = ~w_dp_on;
    // Blink overrides everything, DP included.
    if (r_blink_phase && w_blink_en) begin
      w_seg_next = SEG_BLANK;
    end
    w_sel_next = (w_phase <= i_brightness) ? w_anode : '1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_sh_value    <= '0;
      r_sh_dp       <= '0;
      r_sh_blink    <= '0;
      r_sh_blank_lz <= 1'b0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frame_start <= 1'b0;
      r_seg         <= SEG_BLANK;
      r_digit_sel   <= '1;
    end else begin
      r_cnt         <= r_cnt + 1'b1;
      r_idx         <= w_idx_next;
      r_frame_cnt   <= w_frame_cnt_next;
      r_blink_phase <= w_blink_phase_next;
      r_frame_start <= w_wrap;
      r_seg         <= w_seg_next;
      r_digit_sel   <= w_sel_next;
      if (w_wrap) begin
        r_sh_value    <= i_value;
        r_sh_dp       <= i_dp_mask;
        r_sh_blink    <= i_blink_mask;
        r_sh_blank_lz <= i_blank_lz;
      end
    end
  end

  assign o_digit_sel   = r_digit_sel;
  assign o_seg         = r_seg;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 8 digits, 16-cycle slots, 2-frame blink.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic [7:0]  blink_mask;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [7:0]  digit_sel;
  logic [7:0]  seg;
  logic        frame_start;

  int n_cmp  = 0;
  int n_bad  = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (8),
    .DIV_LOG2    (4),
    .BLINK_FRAMES(2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_value      (value),
    .i_dp_mask    (dp_mask),
    .i_blink_mask (blink_mask),
    .i_blank_lz   (blank_lz),
    .i_brightness (brightness),
    .o_digit_sel  (digit_sel),
    .o_seg        (seg),
    .o_frame_start(frame_start)
  );

  // Advance to 1 time unit after rising edge number `target` since release.
  task automatic goto_edge(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  // First output cycle of digit d in frame f (outputs lag the scan by one edge).
  function automatic int slot_edge(input int f, input int d);
    return 128 * f + 16 * d + 1;
  endfunction

  function automatic logic [7:0] anode(input int d);
    logic [7:0] a;
    a = 8'hFF;
    a[7-d] = 1'b0;
    return a;
  endfunction

  task automatic test_reset();
    value = 32'hFFFF_FFFF; dp_mask = 8'hFF; blink_mask = 8'h00;
    blank_lz = 1'b0; brightness = 4'd15;
    rst_n = 1'b0;
    #12;
    n_cmp++; if (digit_sel !== 8'hFF) begin n_bad++;
      $display("FAIL reset_digit_sel: got %h want ff", digit_sel); end
    n_cmp++; if (seg !== 8'hFF) begin n_bad++;
      $display("FAIL reset_seg: got %h want ff", seg); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++;
      $display("FAIL reset_frame_start: got %b want 0", frame_start); end
  endtask

  task automatic test_scan();
    logic [7:0] exp_seg [8];
    exp_seg = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h11, 8'hC1, 8'h63, 8'h85};
    value = 32'h0123_ABCD; dp_mask = 8'h00; blink_mask = 8'h00;
    blank_lz = 1'b0; brightness = 4'd15;
    do_reset();
    goto_edge(1);
    n_cmp++; if (digit_sel !== 8'h7F) begin n_bad++;
      $display("FAIL scan_first_anode: got %h want 7f", digit_sel); end
    n_cmp++; if (seg !== 8'h03) begin n_bad++;
      $display("FAIL scan_reset_shadow: got %h want 03", seg); end
    for (int d = 0; d < 8; d++) begin
      goto_edge(slot_edge(1, d));
      n_cmp++; if (digit_sel !== anode(d)) begin n_bad++;
        $display("FAIL scan_anode d%0d: got %h want %h", d, digit_sel, anode(d)); end
      n_cmp++; if (seg !== exp_seg[d]) begin n_bad++;
        $display("FAIL scan_seg d%0d: got %h want %h", d, seg, exp_seg[d]); end
      goto_edge(slot_edge(1, d) + 15);
      n_cmp++; if (digit_sel !== anode(d)) begin n_bad++;
        $display("FAIL scan_anode_end d%0d: got %h want %h", d, digit_sel, anode(d)); end
    end
  endtask

  task automatic test_lz();
    logic [7:0] exp1 [8];
    exp1 = '{8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h03};
    value = 32'h0000_00A0; dp_mask = 8'h40; blink_mask = 8'h00;
    blank_lz = 1'b1; brightness = 4'd15;
    do_reset();
    for (int d = 0; d < 8; d++) begin
      goto_edge(slot_edge(1, d));
      n_cmp++; if (seg !== exp1[d]) begin n_bad++;
        $display("FAIL lz_a0 d%0d: got %h want %h", d, seg, exp1[d]); end
    end
    goto_edge(slot_edge(1, 7) + 1);
    value = 32'h0; dp_mask = 8'h00;
    for (int d = 0; d < 8; d++) begin
      goto_edge(slot_edge(2, d));
      n_cmp++; if (seg !== ((d == 7) ? 8'h03 : 8'hFF)) begin n_bad++;
        $display("FAIL lz_zero d%0d: got %h want %h", d, seg, (d == 7) ? 8'h03 : 8'hFF); end
    end
  endtask

  task automatic test_shadow();
    int pulses = 0;
    int p0 = -1;
    int p1 = -1;
    logic [7:0] exp;
    value = 32'h1111_1111; dp_mask = 8'h00; blink_mask = 8'h00;
    blank_lz = 1'b0; brightness = 4'd15;
    do_reset();
    for (int e = 1; e <= 384; e++) begin
      goto_edge(e);
      if (frame_start === 1'b1) begin
        if (pulses == 0) p0 = e;
        if (pulses == 1) p1 = e;
        pulses++;
      end
      if (e > 128 && ((e - 1) % 16) == 0) begin
        exp = (((e - 1) / 128) == 1) ? 8'h9F : 8'h25;
        n_cmp++; if (seg !== exp) begin n_bad++;
          $display("FAIL shadow_seg edge%0d: got %h want %h", e, seg, exp); end
      end
      if (e == slot_edge(1, 3)) value = 32'h2222_2222;
    end
    n_cmp++; if (pulses !== 3) begin n_bad++;
      $display("FAIL frame_start_count: got %0d want 3", pulses); end
    n_cmp++; if (p0 !== 128) begin n_bad++;
      $display("FAIL frame_start_first: got %0d want 128", p0); end
    n_cmp++; if (p1 !== 256) begin n_bad++;
      $display("FAIL frame_start_second: got %0d want 256", p1); end
  endtask

  task automatic test_pwm();
    int lows = 0;
    int bad_onehot = 0;
    value = 32'h0123_ABCD; dp_mask = 8'h00; blink_mask = 8'h00;
    blank_lz = 1'b0; brightness = 4'd3;
    do_reset();
    goto_edge(128);
    for (int e = 129; e <= 144; e++) begin
      goto_edge(e);
      if (digit_sel !== 8'hFF) lows++;
      if (e == 129) begin
        n_cmp++; if (digit_sel !== 8'h7F) begin n_bad++;
          $display("FAIL pwm3_first: got %h want 7f", digit_sel); end
      end
      if (e == 133) begin
        n_cmp++; if (digit_sel !== 8'hFF) begin n_bad++;
          $display("FAIL pwm3_off: got %h want ff", digit_sel); end
      end
    end
    n_cmp++; if (lows !== 4) begin n_bad++;
      $display("FAIL pwm3_count: got %0d want 4", lows); end
    brightness = 4'd0;
    lows = 0;
    for (int e = 145; e <= 160; e++) begin
      goto_edge(e);
      if (digit_sel !== 8'hFF) lows++;
      if (e == 145) begin
        n_cmp++; if (digit_sel !== 8'hBF) begin n_bad++;
          $display("FAIL pwm0_first: got %h want bf", digit_sel); end
      end
    end
    n_cmp++; if (lows !== 1) begin n_bad++;
      $display("FAIL pwm0_count: got %0d want 1", lows); end
    brightness = 4'd15;
    for (int e = 257; e <= 384; e++) begin
      goto_edge(e);
      if ($countones(~digit_sel) != 1) bad_onehot++;
    end
    n_cmp++; if (bad_onehot !== 0) begin n_bad++;
      $display("FAIL anode_onehot: got %0d bad cycles want 0", bad_onehot); end
  endtask

  task automatic test_blink();
    logic [7:0] exp7 [4];
    exp7 = '{8'h85, 8'hFF, 8'hFF, 8'h85};
    value = 32'h0123_ABCD; dp_mask = 8'h00; blink_mask = 8'h01;
    blank_lz = 1'b0; brightness = 4'd15;
    do_reset();
    for (int f = 1; f <= 4; f++) begin
      goto_edge(slot_edge(f, 6));
      n_cmp++; if (seg !== 8'h63) begin n_bad++;
        $display("FAIL blink_other f%0d: got %h want 63", f, seg); end
      goto_edge(slot_edge(f, 7));
      n_cmp++; if (seg !== exp7[f-1]) begin n_bad++;
        $display("FAIL blink_d7 f%0d: got %h want %h", f, seg, exp7[f-1]); end
    end
  endtask

  task automatic test_reset_mid();
    value = 32'h5555_5555; dp_mask = 8'h00; blink_mask = 8'h00;
    blank_lz = 1'b0; brightness = 4'd15;
    do_reset();
    goto_edge(slot_edge(1, 5) + 4);
    n_cmp++; if (digit_sel !== 8'hFB || seg !== 8'h49) begin n_bad++;
      $display("FAIL mid_before: got %h/%h want fb/49", digit_sel, seg); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (digit_sel !== 8'hFF) begin n_bad++;
      $display("FAIL mid_reset_sel: got %h want ff", digit_sel); end
    n_cmp++; if (seg !== 8'hFF) begin n_bad++;
      $display("FAIL mid_reset_seg: got %h want ff", seg); end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
    goto_edge(1);
    n_cmp++; if (digit_sel !== 8'h7F) begin n_bad++;
      $display("FAIL mid_restart_anode: got %h want 7f", digit_sel); end
    for (int d = 0; d < 8; d++) begin
      goto_edge(slot_edge(0, d));
      n_cmp++; if (seg !== 8'h03) begin n_bad++;
        $display("FAIL mid_frame0 d%0d: got %h want 03", d, seg); end
    end
    goto_edge(slot_edge(1, 0));
    n_cmp++; if (seg !== 8'h49) begin n_bad++;
      $display("FAIL mid_frame1: got %h want 49", seg); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_shadow();
    test_pwm();
    test_blink();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment scanner. Drives NUM_DIGITS common-anode digits from a packed hex value.
- Adds five features:
  - clock prescaler for the scan rate
  - frame-consistent shadow latching
  - leading-zero blanking
  - per-digit decimal point and blink
  - 16-level PWM brightness
- Sits between the CPU debug/IO register file and the board display pins.

Parameters:
- NUM_DIGITS, 8: digits scanned; 1..16.
- DIV_LOG2, 16: clocks per digit slot = 2**DIV_LOG2; must be at least 4.
- BLINK_FRAMES, 64: frames per blink half-period; at least 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  4*NUM_DIGITS  hex nibbles; [4N-1:4N-4] is the leftmost digit
- dp_mask  in  NUM_DIGITS  1 = light DP; bit N-1 is the leftmost digit
- blink_mask  in  NUM_DIGITS  1 = digit blinks
- blank_lz  in  1  1 = suppress leading zeros
- brightness  in  4  0 = 1/16 duty, 15 = full duty
- digit_sel  out  NUM_DIGITS  active-low anode enables; bit N-1 is the leftmost digit
- seg  out  8  active-low segments {a,b,c,d,e,f,g,dp}, a = bit 7
- frame_start  out  1  one-cycle pulse when the scan wraps to the leftmost digit

Behaviour:
- Reset (async assert, sync release):
  - digit_sel all 1, seg = 8'hFF, frame_start = 0
  - prescaler = 0, idx = 0, shadow registers = 0, blink_phase = 0, frame counter = 0
- Prescaler cnt[DIV_LOG2-1:0] increments every cycle and wraps freely. tick = (cnt == all ones).
- Scan index:
  - idx 0 is the leftmost digit. On tick, idx advances by 1; N-1 wraps to 0.
  - NUM_DIGITS = 1: idx stays 0 and every tick is a wrap.
- Wrap handling, on a tick where idx == N-1:
  - Shadow registers capture value, dp_mask, blink_mask and blank_lz.
  - frame_start pulses in the following cycle.
  - Frame counter increments; on reaching BLINK_FRAMES-1 it clears and blink_phase toggles.
  - Between wraps, input changes are invisible: no torn frames.
  - The first frame after reset displays the reset shadow (all-zero value), which renders as 0 on every digit, or as blank-but-last when blank_lz = 1.
- Decode path (combinational from the registered state, then registered into seg and digit_sel):
  - Outputs lag (idx, cnt) by exactly 1 cycle.
  - The nibble for idx is shadow_value[4(N-1-idx)+3 -: 4].
  - Hex-to-segment encoding, with the dp bit being 1 (off) before DP merge:
    - 0 = 8'b00000011
    - 1 = 8'b10011111
    - 2 = 8'b00100101
    - 3 = 8'b00001101
    - 4 = 8'b10011001
    - 5 = 8'b01001001
    - 6 = 8'b01000001
    - 7 = 8'b00011111
    - 8 = 8'b00000001
    - 9 = 8'b00001001
    - A = 8'b00010001
    - b = 8'b11000001
    - C = 8'b01100011
    - d = 8'b10000101
    - E = 8'b01100001
    - F = 8'b01110001
  - DP: seg[0] = ~shadow_dp[N-1-idx].
- Leading-zero blank:
  - Applies when shadow_blank_lz = 1, the digit's nibble and every nibble to its left are 0, and idx != N-1.
  - Effect: seg[7:1] forced to all 1; the DP rule still applies.
  - The rightmost digit is never blanked.
- Blink: when blink_phase = 1 and shadow_blink[N-1-idx] = 1, seg = 8'hFF, DP included.
- PWM:
  - phase = cnt[DIV_LOG2-1 -: 4].
  - Anode idx is driven low only while phase <= brightness; otherwise digit_sel is all 1.
  - brightness is sampled live, not shadowed.
- At most one digit_sel bit is low in any cycle.
- Reset mid-frame: outputs go dark immediately; scanning restarts at idx 0 after release.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 8'hFF
  - the 16-entry hex-to-segment constant table and a function hex_to_seg(nibble)
- One sub-module, seg7_lz_mask: combinational; from the value vector, produces the NUM_DIGITS leading-zero blank mask.
- Prescaler, scan FSM, shadow registers, blink counter and output registers stay in the top module.

Test Plan:
All scenarios use NUM_DIGITS = 8, DIV_LOG2 = 4, BLINK_FRAMES = 2, brightness = 15 unless stated.
1. value = 32'h0123ABCD, blank_lz = 0 -> across one frame, each digit_sel bit is low in turn (bit 7 first, 16 cycles each). seg sequence: 03, 9F, 25, 0D, 11, C1, 63, 85.
2. value = 32'h0000_00A0, blank_lz = 1, dp_mask = 8'h40 -> digits 0 and 2-5 show FF, digit 1 shows FE, digit 6 shows 11, digit 7 shows 03. value = 0 -> only digit 7 shows 03.
3. Change value from 32'h11111111 to 32'h22222222 at idx 3 -> the rest of that frame still shows 9F. The next frame shows 25 on all digits. frame_start pulses once per 128 cycles.
4. brightness = 3 -> per 16-cycle slot, the anode is low for exactly 4 cycles (phase 0-3). brightness = 0 -> low for 1 cycle.
5. blink_mask = 8'h01 -> digit 7 alternates between its glyph for 2 frames and FF for 2 frames. Other digits are unaffected.
6. Assert rst_n low during idx 5 -> in the same cycle, digit_sel = FF and seg = FF. After release, the first low anode is bit 7 at cycle 1 (output latency), and the frame shows all 03.
